admode1_operand_fetch: RTL

//  Upstream feeder for the addressing-mode-1 barrel shifter in the ARM data-processing path.

---
 rtl/admode1_pkg.sv | 29 ++
 rtl/admode1_fetch_decode.sv | 48 ++++
 rtl/admode1_operand_fetch.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/admode1_pkg.sv
// Shared types and constants for the addressing-mode-1 operand fetch block.
package admode1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_RN = 3'd1,
    ST_RD_RM = 3'd2,
    ST_RD_RS = 3'd3,
    ST_WAIT  = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  // Destination of the register-file read issued in the previous cycle
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_RN   = 2'd1,
    TAG_RM   = 2'd2,
    TAG_RS   = 2'd3
  } tag_t;

  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

endpackage

// File: rtl/admode1_fetch_decode.sv
// Combinational decode of a data-processing instruction: which registers
// must be read and the shifter fields that are known from the word itself.
module admode1_fetch_decode
  import admode1_pkg::*;
(
  input  logic [31:0] instr,
  output logic        need_rn,
  output logic        need_rm,
  output logic        need_rs,
  output logic        undef,
  output logic        sh_rg,
  output logic [1:0]  sh_typ,
  output logic [7:0]  sh_amount,
  output logic [31:0] sh_base
);

  // Condition, S bit and register fields are consumed by the top level
  logic unused_fields;
  assign unused_fields = ^{instr[31:28], instr[20:12]};

  // Read list and immediate-form shifter fields; undefined encodings read nothing
  always_comb begin
    need_rn   = 1'b0;
    need_rm   = 1'b0;
    need_rs   = 1'b0;
    sh_rg     = 1'b0;
    sh_typ    = SH_LSL;
    sh_amount = 8'h00;
    sh_base   = 32'h0;
    undef     = (instr[27:26] != 2'b00);
    if (!undef) begin
      need_rn = (instr[24:21] != OP_MOV) && (instr[24:21] != OP_MVN);
      if (instr[25]) begin
        sh_base   = {24'h0, instr[7:0]};
        sh_amount = {3'b0, instr[11:8], 1'b0};
        sh_typ    = SH_ROR;
        sh_rg     = 1'b1;
      end else begin
        need_rm   = 1'b1;
        need_rs   = instr[4];
        sh_typ    = instr[6:5];
        sh_rg     = instr[4];
        sh_amount = instr[4] ? 8'h00 : {3'b0, instr[11:7]};
      end
    end
  end

endmodule

// File: rtl/admode1_operand_fetch.sv
// Operand fetch for the addressing-mode-1 shifter: sequences Rn/Rm/Rs reads
// through one synchronous register-file port and presents shifter/ALU inputs.
module admode1_operand_fetch
  import admode1_pkg::*;
#(
  parameter logic [31:0] PC_OFS_IMM = 32'd8,
  parameter logic [31:0] PC_OFS_REG = 32'd12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        rf_re,
  output logic [3:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sh_base,
  output logic [7:0]  sh_amount,
  output logic        sh_rg,
  output logic [1:0]  sh_typ,
  output logic [31:0] rn_val,
  output logic [3:0]  opcode,
  output logic        s_bit,
  output logic [3:0]  rd,
  output logic        undef
);

  state_t      state_q, state_d;
  tag_t        cur_tag, cap_tag_p1;
  logic        accept;
  logic        need_rm_q, need_rs_q;
  logic [3:0]  rn_addr_q, rm_addr_q, rs_addr_q;
  logic [31:0] pc_q;
  logic [3:0]  cap_addr;
  logic [31:0] cap_val;

  logic        dec_need_rn, dec_need_rm, dec_need_rs, dec_undef, dec_rg;
  logic [1:0]  dec_typ;
  logic [7:0]  dec_amount;
  logic [31:0] dec_base;

  admode1_fetch_decode u_decode (
    .instr     (instr),
    .need_rn   (dec_need_rn),
    .need_rm   (dec_need_rm),
    .need_rs   (dec_need_rs),
    .undef     (dec_undef),
    .sh_rg     (dec_rg),
    .sh_typ    (dec_typ),
    .sh_amount (dec_amount),
    .sh_base   (dec_base)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  // A flush in the same cycle wins over a new instruction
  assign accept    = in_valid && in_ready && !flush;

  // Next state, read-port drive and the tag of the read issued this cycle
  always_comb begin
    state_d  = state_q;
    rf_re    = 1'b0;
    rf_raddr = 4'h0;
    cur_tag  = TAG_NONE;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_need_rn)      state_d = ST_RD_RN;
          else if (dec_need_rm) state_d = ST_RD_RM;
          else                  state_d = ST_OUT;
        end
      end
      ST_RD_RN: begin
        rf_re    = 1'b1;
        rf_raddr = rn_addr_q;
        cur_tag  = TAG_RN;
        state_d  = need_rm_q ? ST_RD_RM : ST_WAIT;
      end
      ST_RD_RM: begin
        rf_re    = 1'b1;
        rf_raddr = rm_addr_q;
        cur_tag  = TAG_RM;
        state_d  = need_rs_q ? ST_RD_RS : ST_WAIT;
      end
      ST_RD_RS: begin
        rf_re    = 1'b1;
        rf_raddr = rs_addr_q;
        cur_tag  = TAG_RS;
        state_d  = ST_WAIT;
      end
      ST_WAIT: state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Captured value: r15 reads are replaced by the pipelined pc view
  always_comb begin
    case (cap_tag_p1)
      TAG_RN:  cap_addr = rn_addr_q;
      TAG_RM:  cap_addr = rm_addr_q;
      TAG_RS:  cap_addr = rs_addr_q;
      default: cap_addr = 4'h0;
    endcase
    if (cap_addr == 4'hF) cap_val = pc_q + (need_rs_q ? PC_OFS_REG : PC_OFS_IMM);
    else                  cap_val = rf_rdata;
  end

  // Control state; reset drops any read still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cap_tag_p1 <= TAG_NONE;
      need_rm_q  <= 1'b0;
      need_rs_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_tag_p1 <= flush ? TAG_NONE : cur_tag;
      if (accept) begin
        need_rm_q <= dec_need_rm;
        need_rs_q <= dec_need_rs;
      end
    end
  end

  // Register addresses and pc held for the duration of the instruction
  always_ff @(posedge clk) begin
    if (accept) begin
      rn_addr_q <= instr[19:16];
      rm_addr_q <= instr[3:0];
      rs_addr_q <= instr[11:8];
      pc_q      <= pc;
    end
  end

  // Output registers: seeded on accept, filled in as read data returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_base   <= 32'h0;
      sh_amount <= 8'h00;
      sh_rg     <= 1'b0;
      sh_typ    <= SH_LSL;
      rn_val    <= 32'h0;
      opcode    <= 4'h0;
      s_bit     <= 1'b0;
      rd        <= 4'h0;
      undef     <= 1'b0;
    end else if (accept) begin
      sh_base   <= dec_base;
      sh_amount <= dec_amount;
      sh_rg     <= dec_rg;
      sh_typ    <= dec_typ;
      rn_val    <= 32'h0;
      opcode    <= instr[24:21];
      s_bit     <= instr[20];
      rd        <= instr[15:12];
      undef     <= dec_undef;
    end else if (!flush) begin
      case (cap_tag_p1)
        TAG_RN:  rn_val    <= cap_val;
        TAG_RM:  sh_base   <= cap_val;
        TAG_RS:  sh_amount <= cap_val[7:0];
        default: ;
      endcase
    end
  end

endmodule
